// File: rtl/rob_pkg.sv
// -----------------------------------------------------------------------------
// rob_pkg
//   Shared defaults and index/count types for the ROB status array.
//   rob_idx_t addresses one ROB entry. rob_cnt_t holds an occupancy count of
//   0..2**ROB_DEPTH_LOG2, so it needs one extra bit.
// -----------------------------------------------------------------------------
package rob_pkg;

  localparam int ROB_DEPTH_LOG2 = 5;
  localparam int ROB_NUM_WB     = 8;
  localparam int ROB_COMMIT_W   = 2;

  typedef logic [ROB_DEPTH_LOG2-1:0] rob_idx_t;
  typedef logic [ROB_DEPTH_LOG2:0]   rob_cnt_t;

  // Width of a count that ranges over 0..commit_w.
  function automatic int commit_cnt_w(input int commit_w);
    return $clog2(commit_w + 1);
  endfunction

endpackage : rob_pkg

// File: rtl/rob_commit_scan.sv
// -----------------------------------------------------------------------------
// rob_commit_scan
//   Combinational retire-window scan. Starting at head, it counts consecutive
//   ready entries and stops at the first one that is not ready, at COMMIT_W,
//   or at the occupancy count, whichever comes first. An entry is ready when
//   it is valid and either already done or written back this cycle.
//
// Ports
//   head          in   oldest entry index
//   count         in   occupied entries
//   valid         in   per-entry valid bits
//   done          in   per-entry registered done bits
//   wb_bypass     in   per-entry same-cycle writeback hits
//   commit_count  out  number of retirable entries from head (0..COMMIT_W)
// -----------------------------------------------------------------------------
module rob_commit_scan
  import rob_pkg::*;
#(
  parameter  int DEPTH_LOG2 = ROB_DEPTH_LOG2,
  parameter  int COMMIT_W   = ROB_COMMIT_W,
  localparam int DEPTH      = 2 ** DEPTH_LOG2,
  localparam int CC_W       = commit_cnt_w(COMMIT_W)
) (
  input  logic [DEPTH_LOG2-1:0] head,
  input  logic [DEPTH_LOG2:0]   count,
  input  logic [DEPTH-1:0]      valid,
  input  logic [DEPTH-1:0]      done,
  input  logic [DEPTH-1:0]      wb_bypass,
  output logic [CC_W-1:0]       commit_count
);

  logic [DEPTH_LOG2-1:0] idx;
  logic                  run;

  always_comb begin
    commit_count = '0;
    run          = 1'b1;
    idx          = head;
    for (int k = 0; k < COMMIT_W; k++) begin
      // Natural DEPTH_LOG2-bit overflow gives the wrap past the last entry.
      idx = head + DEPTH_LOG2'(k);
      if (run && (k < int'(count)) && valid[idx] && (done[idx] || wb_bypass[idx])) begin
        commit_count = CC_W'(k + 1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule : rob_commit_scan

// File: rtl/rob_status_array.sv
// -----------------------------------------------------------------------------
// rob_status_array
//   ROB status array. It owns the head/tail pointers, the occupancy count and
//   per-entry valid/done/ctrl bits. Dispatch allocates at the tail. Up to
//   NUM_WB writeback ports mark entries done. The commit stage retires up to
//   COMMIT_W in-order ready entries from the head. Same-cycle writebacks are
//   bypassed into the readiness scan.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   flush            empty the ROB at the next edge; discards all same-cycle activity
//   alloc_valid      dispatch requests one entry
//   alloc_is_ctrl    allocated instruction is a branch/jump
//   alloc_ready      !full, from registered state only
//   alloc_idx        tail pointer (index the next allocation receives)
//   wb_valid/wb_idx  per-port done strobes and target indices
//   commit_en        commit stage takes commit_count entries this cycle
//   head_idx         oldest entry index
//   commit_count     retirable entries from head, capped at COMMIT_W
//   ctrl_in_flight   some valid, not-done control entry exists (registered only)
//   count/empty/full occupancy status
// -----------------------------------------------------------------------------
module rob_status_array
  import rob_pkg::*;
#(
  parameter  int DEPTH_LOG2 = ROB_DEPTH_LOG2,
  parameter  int NUM_WB     = ROB_NUM_WB,
  parameter  int COMMIT_W   = ROB_COMMIT_W,
  localparam int DEPTH      = 2 ** DEPTH_LOG2,
  localparam int CNT_W      = DEPTH_LOG2 + 1,
  localparam int CC_W       = commit_cnt_w(COMMIT_W)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               alloc_valid,
  input  logic                               alloc_is_ctrl,
  output logic                               alloc_ready,
  output logic [DEPTH_LOG2-1:0]              alloc_idx,
  input  logic [NUM_WB-1:0]                  wb_valid,
  input  logic [NUM_WB-1:0][DEPTH_LOG2-1:0]  wb_idx,
  input  logic                               commit_en,
  output logic [DEPTH_LOG2-1:0]              head_idx,
  output logic [CC_W-1:0]                    commit_count,
  output logic                               ctrl_in_flight,
  output logic [DEPTH_LOG2:0]                count,
  output logic                               empty,
  output logic                               full
);

  logic [DEPTH_LOG2-1:0] head_q, head_d;
  logic [DEPTH_LOG2-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      done_q, done_d;
  logic [DEPTH-1:0]      ctrl_q, ctrl_d;

  logic [DEPTH-1:0]      wb_hit;
  logic                  alloc_fire;
  logic [CC_W-1:0]       commit_num;

  // Per-entry OR of all writeback ports; duplicate indices simply merge.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    wb_hit = '0;
    for (int p = 0; p < NUM_WB; p++) begin
      if (wb_valid[p]) wb_hit[wb_idx[p]] = 1'b1;
    end
  end

  // Status outputs come from registered state only; in particular nothing
  // from commit_en reaches alloc_ready.
  assign full           = (count_q == CNT_W'(DEPTH));
  assign empty          = (count_q == '0);
  assign alloc_ready    = !full;
  assign alloc_idx      = tail_q;
  assign head_idx       = head_q;
  assign count          = count_q;
  assign ctrl_in_flight = |(valid_q & ctrl_q & ~done_q);

  rob_commit_scan #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .COMMIT_W   (COMMIT_W)
  ) u_commit_scan (
    .head         (head_q),
    .count        (count_q),
    .valid        (valid_q),
    .done         (done_q),
    .wb_bypass    (wb_hit),
    .commit_count (commit_count)
  );

  always_comb begin
    alloc_fire = alloc_valid && !full;
    commit_num = commit_en ? commit_count : '0;

    // Writebacks only land on valid entries.
    valid_d = valid_q;
    done_d  = done_q | (wb_hit & valid_q);
    ctrl_d  = ctrl_q;
    head_d  = head_q + DEPTH_LOG2'(commit_num);
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(commit_num);

    for (int k = 0; k < COMMIT_W; k++) begin
      if (k < int'(commit_num)) valid_d[head_q + DEPTH_LOG2'(k)] = 1'b0;
    end

    // The tail slot is never valid when allocation is accepted, so it cannot
    // collide with a retiring entry; writing done=0 here overrides any
    // same-cycle writeback that named the still-empty slot.
    if (alloc_fire) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      ctrl_d[tail_q]  = alloc_is_ctrl;
      tail_d          = tail_q + DEPTH_LOG2'(1);
    end

    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      ctrl_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      // NOTE: the per-entry bits are ordinary flops, not RAM, so they are
      // cleared on reset with the rest of the state.
      valid_q <= '0;
      done_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ctrl_q  <= ctrl_d;
    end
  end

endmodule : rob_status_array

// File: tb/tb_rob_status_array.sv
// -----------------------------------------------------------------------------
// tb_rob_status_array
//   Self-checking bench for rob_status_array (default parameters). The
//   reference model keeps the occupied window as an ordered queue of
//   {index, done, ctrl} records from head to tail.
// -----------------------------------------------------------------------------
module tb_rob_status_array;
  import rob_pkg::*;

  localparam int DL2      = ROB_DEPTH_LOG2;
  localparam int DEPTH    = 2 ** DL2;
  localparam int NUM_WB   = ROB_NUM_WB;
  localparam int COMMIT_W = ROB_COMMIT_W;
  localparam int CC_W     = commit_cnt_w(COMMIT_W);

  logic                          clk = 1'b0;
  logic                          rst, flush, alloc_valid, alloc_is_ctrl, commit_en;
  logic                          alloc_ready, ctrl_in_flight, empty, full;
  rob_idx_t                      alloc_idx, head_idx;
  rob_cnt_t                      count;
  logic [NUM_WB-1:0]             wb_valid;
  logic [NUM_WB-1:0][DL2-1:0]    wb_idx;
  logic [CC_W-1:0]               commit_count;

  int n_checks = 0;
  int n_err    = 0;

  rob_status_array #(
    .DEPTH_LOG2 (DL2),
    .NUM_WB     (NUM_WB),
    .COMMIT_W   (COMMIT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .alloc_valid    (alloc_valid),
    .alloc_is_ctrl  (alloc_is_ctrl),
    .alloc_ready    (alloc_ready),
    .alloc_idx      (alloc_idx),
    .wb_valid       (wb_valid),
    .wb_idx         (wb_idx),
    .commit_en      (commit_en),
    .head_idx       (head_idx),
    .commit_count   (commit_count),
    .ctrl_in_flight (ctrl_in_flight),
    .count          (count),
    .empty          (empty),
    .full           (full)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- model
  typedef struct {
    int idx;
    bit done;
    bit ctrl;
  } ent_t;

  ent_t q[$];
  int   m_head = 0;

  function automatic bit wb_hits(input int idx);
    for (int p = 0; p < NUM_WB; p++)
      if (wb_valid[p] && int'(wb_idx[p]) == idx) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_cc();
    int n = 0;
    while (n < COMMIT_W && n < q.size() && (q[n].done || wb_hits(q[n].idx))) n++;
    return n;
  endfunction

  function automatic int m_tail();
    return (m_head + q.size()) % DEPTH;
  endfunction

  function automatic bit m_cif();
    foreach (q[i]) if (q[i].ctrl && !q[i].done) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    int   tail;
    int   cc;
    bit   can;
    ent_t e;
    if (rst || flush) begin
      q.delete();
      m_head = 0;
    end else begin
      tail = m_tail();
      can  = q.size() < DEPTH;
      cc   = m_cc();
      foreach (q[i]) if (wb_hits(q[i].idx)) q[i].done = 1'b1;
      if (commit_en) begin
        repeat (cc) void'(q.pop_front());
        m_head = (m_head + cc) % DEPTH;
      end
      if (alloc_valid && can) begin
        e.idx  = tail;
        e.done = 1'b0;
        e.ctrl = alloc_is_ctrl;
        q.push_back(e);
      end
    end
  endtask

  // ---------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model();
    check("head_idx",       head_idx,       m_head);
    check("alloc_idx",      alloc_idx,      m_tail());
    check("count",          count,          q.size());
    check("empty",          empty,          q.size() == 0);
    check("full",           full,           q.size() == DEPTH);
    check("alloc_ready",    alloc_ready,    q.size() != DEPTH);
    check("commit_count",   commit_count,   m_cc());
    check("ctrl_in_flight", ctrl_in_flight, m_cif());
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".head_idx"},       head_idx,       0);
    check({tag, ".alloc_idx"},      alloc_idx,      0);
    check({tag, ".count"},          count,          0);
    check({tag, ".empty"},          empty,          1);
    check({tag, ".full"},           full,           0);
    check({tag, ".alloc_ready"},    alloc_ready,    1);
    check({tag, ".commit_count"},   commit_count,   0);
    check({tag, ".ctrl_in_flight"}, ctrl_in_flight, 0);
  endtask

  task automatic idle();
    rst           = 1'b0;
    flush         = 1'b0;
    alloc_valid   = 1'b0;
    alloc_is_ctrl = 1'b0;
    commit_en     = 1'b0;
    wb_valid      = '0;
    for (int p = 0; p < NUM_WB; p++) wb_idx[p] = '0;
  endtask

  task automatic set_wb(input logic [NUM_WB-1:0] mask, input int idx);
    wb_valid = mask;
    for (int p = 0; p < NUM_WB; p++) wb_idx[p] = rob_idx_t'(idx);
  endtask

  // Ends 1 time unit after a rising edge, with the model advanced.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Inputs already driven: compare all outputs with the model, then clock.
  task automatic step();
    #1;
    check_model();
    tick();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------- vectors
  // exp_cc is sampled before the edge (includes bypass); the rest after it.
  typedef struct {
    bit                alloc;
    bit                is_ctrl;
    logic [NUM_WB-1:0] wbv;
    int                wb_at;
    bit                commit;
    int                exp_cc;
    int                exp_head;
    int                exp_count;
    bit                exp_cif;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int tmp;

    vecs[0]  = '{1, 0, 8'h00, 0, 0,  0, 0, 1, 0};
    vecs[1]  = '{1, 0, 8'h00, 0, 0,  0, 0, 2, 0};
    vecs[2]  = '{1, 0, 8'h00, 0, 0,  0, 0, 3, 0};
    vecs[3]  = '{0, 0, 8'h01, 1, 0,  0, 0, 3, 0};  // idx 1 done, head not
    vecs[4]  = '{0, 0, 8'h01, 0, 1,  2, 2, 1, 0};  // bypass idx 0, retire 2
    vecs[5]  = '{1, 1, 8'h00, 0, 0,  0, 2, 2, 1};  // branch at idx 3
    vecs[6]  = '{0, 0, 8'h03, 3, 0,  0, 2, 2, 0};  // branch resolved
    vecs[7]  = '{0, 0, 8'h01, 2, 1,  2, 4, 0, 0};
    vecs[8]  = '{1, 1, 8'h00, 0, 0,  0, 4, 1, 1};  // branch at idx 4
    vecs[9]  = '{0, 0, 8'h01, 4, 0,  1, 4, 1, 0};
    vecs[10] = '{0, 0, 8'h00, 0, 1,  1, 5, 0, 0};
    vecs[11] = '{0, 0, 8'hFF, 5, 1,  0, 5, 0, 0};  // wb while empty

    // Reset state
    do_reset();
    #1;
    check_reset_vals("reset");

    // Table-driven sequence
    foreach (vecs[i]) begin
      alloc_valid   = vecs[i].alloc;
      alloc_is_ctrl = vecs[i].is_ctrl;
      set_wb(vecs[i].wbv, vecs[i].wb_at);
      commit_en     = vecs[i].commit;
      #1;
      check_model();
      check($sformatf("vec%0d.commit_count", i), commit_count, vecs[i].exp_cc);
      tick();
      idle();
      #1;
      check($sformatf("vec%0d.head_idx", i),       head_idx,       vecs[i].exp_head);
      check($sformatf("vec%0d.count", i),          count,          vecs[i].exp_count);
      check($sformatf("vec%0d.ctrl_in_flight", i), ctrl_in_flight, vecs[i].exp_cif);
    end

    // Duplicate writeback ports and writeback to an unallocated entry
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc_valid   = 1'b1;
      alloc_is_ctrl = (i == 7);
      step();
    end
    idle();
    #1;
    check("dup.cif_before", ctrl_in_flight, 1);
    wb_valid  = 8'b0000_0111;
    wb_idx[0] = rob_idx_t'(7);
    wb_idx[1] = rob_idx_t'(7);
    wb_idx[2] = rob_idx_t'(20);
    step();
    idle();
    #1;
    check("dup.cif_after", ctrl_in_flight, 0);
    check("dup.count", count, 8);
    for (int i = 0; i < 13; i++) begin
      alloc_valid   = 1'b1;
      alloc_is_ctrl = (i == 12);
      step();
    end
    idle();
    #1;
    check("dup.idx20_not_done", ctrl_in_flight, 1);
    check("dup.alloc_idx", alloc_idx, 21);

    // Full: allocation refused even alongside a commit
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      alloc_valid = 1'b1;
      step();
    end
    idle();
    #1;
    check("full.full", full, 1);
    check("full.alloc_ready", alloc_ready, 0);
    check("full.count", count, DEPTH);
    alloc_valid = 1'b1;
    commit_en   = 1'b1;
    set_wb(8'h01, 0);
    #1;
    check("full.ready_with_commit", alloc_ready, 0);
    check("full.commit_count", commit_count, 1);
    tick();
    idle();
    #1;
    check("full.count_after", count, DEPTH - 1);
    check("full.head_after", head_idx, 1);
    check("full.alloc_idx_after", alloc_idx, 0);
    check_model();

    // Pointer wrap: head 30, tail 2
    do_reset();
    for (int i = 0; i < 30; i++) begin
      alloc_valid = 1'b1;
      step();
    end
    idle();
    for (int i = 0; i < 15; i++) begin
      wb_valid  = 8'b0000_0011;
      wb_idx[0] = rob_idx_t'(m_head);
      wb_idx[1] = rob_idx_t'((m_head + 1) % DEPTH);
      commit_en = 1'b1;
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1;
      step();
    end
    idle();
    #1;
    check("wrap.head", head_idx, 30);
    check("wrap.alloc_idx", alloc_idx, 2);
    wb_valid  = 8'b0000_0111;
    wb_idx[0] = rob_idx_t'(30);
    wb_idx[1] = rob_idx_t'(31);
    wb_idx[2] = rob_idx_t'(0);
    step();
    idle();
    commit_en = 1'b1;
    #1;
    check("wrap.cc_first", commit_count, 2);
    tick();
    #1;
    check("wrap.head_first", head_idx, 0);
    check("wrap.cc_second", commit_count, 1);
    tick();
    idle();
    #1;
    check("wrap.head_second", head_idx, 1);
    check("wrap.count", count, 1);
    check_model();

    // Flush discards same-cycle alloc, writeback and commit
    do_reset();
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1'b1;
      step();
    end
    idle();
    flush       = 1'b1;
    alloc_valid = 1'b1;
    commit_en   = 1'b1;
    set_wb(8'hFF, 0);
    step();
    idle();
    #1;
    check("flush.count", count, 0);
    check("flush.empty", empty, 1);
    check("flush.head_idx", head_idx, 0);
    check("flush.alloc_idx", alloc_idx, 0);
    check("flush.commit_count", commit_count, 0);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      bit drain;
      drain         = ((c / 250) % 2) == 0;
      alloc_valid   = $urandom_range(0, 3) != 0;
      alloc_is_ctrl = $urandom_range(0, 3) == 0;
      commit_en     = drain ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      flush         = $urandom_range(0, 99) == 0;
      rst           = $urandom_range(0, 299) == 0;
      for (int p = 0; p < NUM_WB; p++) begin
        wb_valid[p] = $urandom_range(0, 3) == 0;
        if ($urandom_range(0, 3) != 0) tmp = m_head + int'($urandom_range(0, q.size()));
        else                           tmp = int'($urandom_range(0, DEPTH - 1));
        wb_idx[p] = rob_idx_t'(tmp % DEPTH);
      end
      step();
    end

    // Reset in the middle of activity
    idle();
    for (int i = 0; i < 6; i++) begin
      alloc_valid   = 1'b1;
      alloc_is_ctrl = 1'b1;
      step();
    end
    rst         = 1'b1;
    alloc_valid = 1'b1;
    commit_en   = 1'b1;
    set_wb(8'hFF, m_head);
    tick();
    idle();
    #1;
    check_reset_vals("midreset");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_rob_status_array

// File: doc/rob_status_array.md
# rob_status_array

Parametrised ROB status array. It owns the head and tail pointers, and per-entry valid, done and control bits. It accepts done-marking from NUM_WB writeback ports and reports how many in-order entries at the head can retire this cycle, up to COMMIT_W, including same-cycle writeback bypass. It also flags any unresolved branch or jump in flight. It sits between the dispatch stage, the CDB and functional-unit writeback ports, and the commit stage. It replaces the single-commit, fixed-depth, fixed-port done-bit array.

## Interface
- DEPTH_LOG2, default 5: ROB depth is 2**DEPTH_LOG2 entries.
- NUM_WB, default 8: number of writeback (done-marking) ports.
- COMMIT_W, default 2: maximum entries retired per cycle (1..4).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  mispredict recovery; empties the ROB next edge.
- alloc_valid  in  1  dispatch requests one entry.
- alloc_is_ctrl  in  1  the allocated instruction is a branch or jump.
- alloc_ready  out  1  equals !full (registered state only).
- alloc_idx  out  DEPTH_LOG2  tail pointer; index the allocation receives.
- wb_valid  in  NUM_WB  per-port done strobe.
- wb_idx  in  NUM_WB x DEPTH_LOG2  per-port ROB index to mark done.
- commit_en  in  1  commit stage takes commit_count entries this cycle.
- head_idx  out  DEPTH_LOG2  oldest entry index.
- commit_count  out  $clog2(COMMIT_W+1)  number of consecutive ready entries from head, capped at COMMIT_W.
- ctrl_in_flight  out  1  some valid, not-done control entry exists.
- count  out  DEPTH_LOG2+1  occupied entries.
- empty  out  1  count == 0.
- full  out  1  count == 2**DEPTH_LOG2.

## Operation
- An entry is ready iff valid && (done_q || a same-cycle wb_valid[p] with wb_idx[p] == its index).
- commit_count is the number of consecutive ready entries starting at head, counting at most COMMIT_W and never past count.
- Retire: when commit_en is high, clear valid for head..head+commit_count-1 and advance head by commit_count.
- Allocate: when alloc_valid && alloc_ready, set valid=1, done=0, ctrl=alloc_is_ctrl at tail, then advance tail.
- Writeback: for each port with wb_valid high and a valid target entry, set done=1.
  - Writebacks to invalid entries are ignored.
  - Duplicate indices across ports are ORed together.
- Priority is rst > flush > (retire, allocate, writeback), which apply concurrently.
- Flush clears all valid bits, head=tail=0, count=0. All same-cycle alloc, writeback and commit activity is discarded.
- count_next = count + alloc accepted − committed entries (committed only when commit_en).
- Pointers wrap modulo 2**DEPTH_LOG2 using natural DEPTH_LOG2-bit overflow.
- ctrl_in_flight = OR over entries of (valid && ctrl && !done_q). It uses registered state only, with no bypass.

## Timing
- Reset values:
  - head_idx=0, alloc_idx=0, count=0.
  - empty=1, full=0, alloc_ready=1.
  - commit_count=0, ctrl_in_flight=0.
  - All valid, done and ctrl bits are 0.
- Writeback to commit is 0 cycles: a head entry written back in cycle N can be counted in commit_count in cycle N.
- Allocate to commit takes at least 1 cycle: an entry allocated in cycle N is valid from N+1 and cannot retire before N+1.
- When full, allocation is refused even if a commit frees space the same cycle. There is no combinational path from commit_en to alloc_ready.
- When empty, commit_count=0. A writeback in the same cycle cannot create readiness because no entry is valid.
- Simultaneous allocate and commit when count==1 leaves count=1 with head advanced.
- Reset or flush mid-operation takes effect at the next edge. All outputs hold their reset values the cycle after.

## Structure
- Package rob_pkg holds:
  - the DEPTH_LOG2 default;
  - typedef rob_idx_t (logic [DEPTH_LOG2-1:0]);
  - typedef rob_cnt_t (logic [DEPTH_LOG2:0]).
- Sub-module rob_commit_scan is combinational. From head, count, the valid and done vectors and the wb bypass vector, it produces commit_count. Instantiate it once.

## Test plan
- Reset, then 3 allocs, then wb on idx 1 only -> commit_count=0. Then wb idx 0 -> commit_count=2 in the same cycle (COMMIT_W=2). With commit_en, head_idx=2 and count=1 the next cycle.
- Fill 32 entries -> full=1, alloc_ready=0. An alloc attempt alongside a commit of 1 -> allocation refused, count=31.
- Head at 30, tail wrapped to 2, entries 30, 31, 0 done -> commit_count=2, then 1. head_idx wraps to 0, then 1.
- Alloc a branch at idx 4 -> ctrl_in_flight=1 the next cycle. wb idx 4 -> ctrl_in_flight=0 one cycle later.
- 5 entries valid, flush together with alloc_valid and wb_valid -> next cycle count=0, empty=1, head_idx=alloc_idx=0, commit_count=0.
- Two ports writing idx 7 plus a wb to unallocated idx 20 -> idx 7 done, idx 20 stays invalid. A later alloc reaching idx 20 shows done=0.
